// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;
  typedef logic [7:0] addr_t;

  typedef struct packed {
    logic [7:0] opcode1;
    logic [7:0] opcode2;
    addr_t      pc;
  } instr_t;

  localparam int FETCH_DEPTH = 2;
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);
  // FIFO pointers wrap naturally, so FETCH_DEPTH must stay a power of two.
  localparam int PTR_W       = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {HI = 1'b0, LO = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between byte assembly and the CPU.
// Flush wins over push/pop; a push into a full buffer is accepted only
// when the same edge pops.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  instr_t din,
  output logic   full,
  output logic   empty,
  output cnt_t   count,
  output instr_t head
);
  instr_t           mem [FETCH_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == cnt_t'(FETCH_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Byte-wide ROM fetch that assembles 2-byte instructions and presents
// them to the CPU through a small buffer with a valid/ready handshake.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] rom_address,
  output logic       rom_rd_en,
  input  logic [7:0] rom_data,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect,
  input  logic [7:0] redirect_addr
);
  fetch_state_t state;
  addr_t        fetch_addr, rsp_addr, pc_q;
  logic [7:0]   op1_q;
  logic         rsp_vld;   // rom_data this cycle answers a live read
  logic         iss_lo;    // next issued byte is the second of an instruction
  cnt_t         infl;      // instructions started but not yet pushed
  logic         push, pop, full, empty, iss_lo_nxt, issue_first, can_start;
  cnt_t         count, infl_nxt, cnt_nxt;
  instr_t       head, din;

  assign issue_first = rom_rd_en && !iss_lo;
  assign push        = rsp_vld && (state == LO) && !redirect && (!full || pop);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign din         = '{opcode1: op1_q, opcode2: rom_data, pc: pc_q};

  assign rom_address = fetch_addr;
  assign instr_valid = !empty;
  assign opcode1     = head.opcode1;
  assign opcode2     = head.opcode2;
  assign instr_pc    = head.pc;

  // Credit bookkeeping for the next cycle's read decision. The second byte
  // of an already started instruction always issues; only new starts are
  // throttled against buffer space.
  always_comb begin
    iss_lo_nxt = iss_lo ^ rom_rd_en;
    infl_nxt   = infl + cnt_t'(issue_first) - cnt_t'(push);
    cnt_nxt    = count + cnt_t'(push) - cnt_t'(pop);
    can_start  = (int'(cnt_nxt) + int'(infl_nxt)) < FETCH_DEPTH;
  end

  // Fetch control and HI/LO byte assembly FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HI;
      fetch_addr <= '0;
      rsp_addr   <= '0;
      rsp_vld    <= 1'b0;
      iss_lo     <= 1'b0;
      infl       <= '0;
      rom_rd_en  <= 1'b0;
      op1_q      <= '0;
      pc_q       <= '0;
    end else if (redirect) begin
      // Buffer is flushed, so a fresh start always has credit.
      state      <= HI;
      fetch_addr <= redirect_addr;
      rsp_vld    <= 1'b0;
      iss_lo     <= 1'b0;
      infl       <= '0;
      rom_rd_en  <= 1'b1;
    end else begin
      if (rom_rd_en) fetch_addr <= fetch_addr + 8'd1;
      rsp_vld   <= rom_rd_en;
      rsp_addr  <= fetch_addr;
      iss_lo    <= iss_lo_nxt;
      infl      <= infl_nxt;
      rom_rd_en <= iss_lo_nxt || can_start;
      if (rsp_vld) begin
        if (state == HI) begin
          op1_q <= rom_data;
          pc_q  <= rsp_addr;
          state <= LO;
        end else begin
          state <= HI;
        end
      end
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch against a ROM model and an
// instruction-stream reference (pc, rom[pc], rom[pc+1], pc += 2).
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_address, rom_data = 8'h00;
  logic       rom_rd_en;
  logic [7:0] opcode1, opcode2, instr_pc, redirect_addr = 8'h00;
  logic       instr_valid, instr_ready = 1'b0, redirect = 1'b0;

  logic [7:0] rom [256];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // ROM: registered read, junk on the bus when not strobed.
  always @(posedge clk) rom_data <= rom_rd_en ? rom[rom_address] : 8'($urandom);

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .rom_address   (rom_address),
    .rom_rd_en     (rom_rd_en),
    .rom_data      (rom_data),
    .opcode1       (opcode1),
    .opcode2       (opcode2),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_rden"},  32'(rom_rd_en), 32'd0);
    chk({tag, "_outs"},  32'({rom_address, opcode1, opcode2, instr_pc}), 32'd0);
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] pc);
    logic [7:0] pn;
    pn = pc + 8'd1;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'({opcode1, opcode2, instr_pc}), 32'({rom[pc], rom[pn], pc}));
  endtask

  // Release reset (held at entry) with ready high and check start-up timing.
  task automatic boot(input string tag);
    reset = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b1;
    cyc(1);
    chk({tag, "_rd0"}, 32'({rom_rd_en, rom_address}), 32'({1'b1, 8'h00}));
    chk({tag, "_v0"}, 32'(instr_valid), 32'd0);
    cyc(2);
    chk({tag, "_v2"}, 32'(instr_valid), 32'd0);
    cyc(1);
    chk_instr({tag, "_i0"}, 8'h00);
    cyc(1);
    chk({tag, "_v4"}, 32'(instr_valid), 32'd0);
    cyc(1);
    chk_instr({tag, "_i2"}, 8'h02);
    cyc(2);
    chk_instr({tag, "_i4"}, 8'h04);
  endtask

  logic [7:0]  exp_pc, raddr;
  logic [23:0] held;
  logic        hold_pend, rdy, rdr;
  int          idle;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    rom[0] = 8'h10; rom[1] = 8'hFF; rom[2] = 8'h30;
    rom[3] = 8'h83; rom[4] = 8'h20; rom[5] = 8'h83;
    rom[255] = 8'h21;

    // Reset hold and first boot
    cyc(3);
    chk_zero("reset_hold");
    boot("boot1");

    // Backpressure: two buffered, reads stop, head held, then drains in order
    reset = 1'b1; instr_ready = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(6);
    for (int i = 0; i < 10; i++) begin
      chk("stall_rden", 32'(rom_rd_en), 32'd0);
      chk_instr("stall_hold", 8'h00);
      cyc(1);
    end
    instr_ready = 1'b1;
    cyc(1);
    chk_instr("release_next", 8'h02);

    // Redirect to 0x04 while 30/83 is accepted
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(6);
    chk_instr("pre_redir", 8'h02);
    redirect = 1'b1; redirect_addr = 8'h04;
    cyc(1);
    redirect = 1'b0;
    chk("redir_gap1", 32'(instr_valid), 32'd0);
    cyc(2);
    chk("redir_gap3", 32'(instr_valid), 32'd0);
    cyc(1);
    chk_instr("redir_i4", 8'h04);
    cyc(2);
    chk_instr("redir_i6", 8'h06);

    // Redirect to 0xFF: opcode2 wraps to address 0
    redirect = 1'b1; redirect_addr = 8'hFF;
    cyc(1);
    redirect = 1'b0;
    cyc(3);
    chk_instr("wrap_ff", 8'hFF);
    cyc(2);
    chk_instr("wrap_01", 8'h01);

    // Reset pulse mid-fetch
    reset = 1'b1;
    cyc(1);
    chk_zero("rst_pulse");
    boot("boot2");

    // Redirect coincident with reset
    cyc(1);
    reset = 1'b1; redirect = 1'b1; redirect_addr = 8'h80;
    cyc(1);
    chk_zero("rst_redir");
    boot("boot3");

    // Randomized traffic against the instruction-stream reference
    reset = 1'b1; redirect = 1'b0;
    cyc(1);
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    reset = 1'b0;
    exp_pc = 8'h00; hold_pend = 1'b0; idle = 0; held = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_pend) begin
        chk("rnd_hold_v", 32'(instr_valid), 32'd1);
        chk("rnd_hold", 32'({opcode1, opcode2, instr_pc}), 32'(held));
      end
      if (instr_valid) idle = 0; else idle++;
      chk("rnd_idle_bound", 32'(idle <= 6), 32'd1);
      rdy = ($urandom_range(3) != 0);
      rdr = ($urandom_range(29) == 0);
      raddr = 8'($urandom);
      if (instr_valid && rdy && !rdr) begin
        chk_instr("rnd_hs", exp_pc);
        exp_pc = exp_pc + 8'd2;
      end
      hold_pend = instr_valid && !rdy && !rdr;
      held = {opcode1, opcode2, instr_pc};
      if (rdr) begin
        exp_pc = raddr;
        idle = 0;
      end
      instr_ready = rdy; redirect = rdr; redirect_addr = raddr;
      cyc(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
